// File: rtl/regfile_mp.sv
// Multi-port register file: registered reads with write-to-read bypass, highest-index write
// wins, and a synchronous clear sweep after reset. Optional macro: REGFILE_ZERO_REG_EN.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] din,
  output logic [NUM_RD*DATA_W-1:0] dout,
  output logic                     busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q     [Depth];
  logic [Depth-1:0]  ent_we;
  logic [DATA_W-1:0] ent_wdata [Depth];

  logic [ADDR_W-1:0] raddr_a [NUM_RD];
  logic [ADDR_W-1:0] waddr_a [NUM_WR];
  logic [DATA_W-1:0] din_a   [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;

  logic [DATA_W-1:0] rd_val [NUM_RD];
  logic [DATA_W-1:0] dout_q [NUM_RD];
  logic [DATA_W-1:0] dout_d [NUM_RD];

  // Unpack the flat port buses
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign raddr_a[i]                  = raddr[i*ADDR_W +: ADDR_W];
    assign dout[i*DATA_W +: DATA_W]    = dout_q[i];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign waddr_a[j] = waddr[j*ADDR_W +: ADDR_W];
    assign din_a[j]   = din[j*DATA_W +: DATA_W];
  end

  assign busy = (state_q == StClear);

  // Sweep FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Qualified write enables; traffic is ignored while sweeping
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = we[j] && (state_q == StReady);
`ifdef REGFILE_ZERO_REG_EN
      if (waddr_a[j] == '0) begin
        wr_ok[j] = 1'b0;
      end
`endif
    end
  end

  // Per-entry write decode; ascending loop lets the highest port index win a conflict
  always_comb begin
    for (int k = 0; k < Depth; k++) begin
      ent_we[k]    = 1'b0;
      ent_wdata[k] = '0;
    end
    if (state_q == StClear) begin
      ent_we[cnt_q] = 1'b1;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          ent_we[waddr_a[j]]    = 1'b1;
          ent_wdata[waddr_a[j]] = din_a[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < Depth; k++) begin
        if (ent_we[k]) begin
          mem_q[k] <= ent_wdata[k];
        end
      end
    end
  end

  // Read value is the post-write content of the entry, which covers the bypass case
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (ent_we[raddr_a[i]]) begin
        rd_val[i] = ent_wdata[raddr_a[i]];
      end else begin
        rd_val[i] = mem_q[raddr_a[i]];
      end
`ifdef REGFILE_ZERO_REG_EN
      if (raddr_a[i] == '0) begin
        rd_val[i] = '0;
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      dout_d[i] = dout_q[i];
      if (state_q == StClear) begin
        dout_d[i] = '0;
      end else if (re[i]) begin
        dout_d[i] = rd_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst) begin
        dout_q[i] <= '0;
      end else begin
        dout_q[i] <= dout_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters) against an array-based reference
// model of the file's post-write contents.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        busy;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [31:0] m_mem [0:31];
  logic [31:0] m_dout [0:1];
  bit          m_clear = 1'b0;
  int          m_cnt   = 0;

  regfile_mp dut (
    .clk   (clk),
    .rst   (rst),
    .re    (re),
    .raddr (raddr),
    .we    (we),
    .waddr (waddr),
    .din   (din),
    .dout  (dout),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs, then step the DUT.
  task automatic clock_edge();
    logic [31:0] nm [0:31];
    logic [4:0]  a;
    if (rst) begin
      m_clear   = 1'b1;
      m_cnt     = 0;
      m_dout[0] = 32'h0;
      m_dout[1] = 32'h0;
    end else if (m_clear) begin
      m_mem[m_cnt] = 32'h0;
      if (m_cnt == 31) m_clear = 1'b0;
      m_cnt = m_cnt + 1;
      m_dout[0] = 32'h0;
      m_dout[1] = 32'h0;
    end else begin
      nm = m_mem;
      for (int j = 0; j < 2; j++) begin
        a = waddr[j*5 +: 5];
`ifdef REGFILE_ZERO_REG_EN
        if (we[j] && a != 5'd0) nm[a] = din[j*32 +: 32];
`else
        if (we[j]) nm[a] = din[j*32 +: 32];
`endif
      end
      for (int i = 0; i < 2; i++) begin
        a = raddr[i*5 +: 5];
        if (re[i]) begin
`ifdef REGFILE_ZERO_REG_EN
          m_dout[i] = (a == 5'd0) ? 32'h0 : nm[a];
`else
          m_dout[i] = nm[a];
`endif
        end
      end
      m_mem = nm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    re  = 2'b00;
    we  = 2'b00;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    clock_edge();
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy);
    else passes++;
    checks++;
    if (dout !== 64'h0) $display("FAIL reset_dout: got %h want 0", dout);
    else passes++;
    rst = 1'b0;
    re  = 2'b11;
    n   = 1;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      raddr = 10'($urandom);
      clock_edge();
      checks++;
      if (dout !== 64'h0) $display("FAIL sweep_dout: got %h want 0", dout);
      else passes++;
      if (busy === 1'b1) n++;
    end
    checks++;
    if (n !== 32) $display("FAIL sweep_len: got %0d busy cycles want 32", n);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL sweep_end: busy %b want 0", busy);
    else passes++;
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      clock_edge();
      checks++;
      if (dout !== 64'h0) $display("FAIL clear_read addr %0d: got %h want 0", a, dout);
      else passes++;
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    we = 2'b01; waddr[4:0] = 5'd7; din[31:0] = 32'h12345678;
    clock_edge();
    idle();
    re = 2'b01; raddr[4:0] = 5'd7;
    clock_edge();
    checks++;
    if (dout[31:0] !== 32'h12345678) $display("FAIL write_read: got %h want 12345678", dout[31:0]);
    else passes++;
    re = 2'b00; raddr[4:0] = 5'd2;
    clock_edge();
    checks++;
    if (dout[31:0] !== 32'h12345678) $display("FAIL read_hold: got %h want 12345678", dout[31:0]);
    else passes++;
  endtask

  task automatic test_bypass();
    idle();
    we = 2'b01; waddr[4:0] = 5'd3; din[31:0] = 32'hAAAA0000;
    clock_edge();
    idle();
    we = 2'b10; waddr[9:5] = 5'd3; din[63:32] = 32'h55550000;
    re = 2'b11; raddr = {5'd3, 5'd3};
    clock_edge();
    checks++;
    if (dout !== {2{32'h55550000}}) $display("FAIL bypass: got %h want 5555000055550000", dout);
    else passes++;
    idle();
  endtask

  task automatic test_conflict();
    idle();
    we = 2'b11; waddr = {5'd9, 5'd9}; din = {32'h22222222, 32'h11111111};
    re = 2'b01; raddr[4:0] = 5'd9;
    clock_edge();
    checks++;
    if (dout[31:0] !== 32'h22222222) $display("FAIL conflict_bypass: got %h want 22222222", dout[31:0]);
    else passes++;
    idle();
    clock_edge();
    re = 2'b10; raddr[9:5] = 5'd9;
    clock_edge();
    checks++;
    if (dout[63:32] !== 32'h22222222) $display("FAIL conflict_mem: got %h want 22222222", dout[63:32]);
    else passes++;
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    idle();
    rst = 1'b1;
    clock_edge();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      we = 2'b11; re = 2'($urandom);
      waddr = 10'($urandom); raddr = 10'($urandom); din = {$urandom, $urandom};
      clock_edge();
    end
    rst = 1'b1;
    clock_edge();
    rst = 1'b0;
    n = 1;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      we = 2'b11; re = 2'b11;
      waddr = 10'($urandom); raddr = 10'($urandom); din = {$urandom, $urandom};
      clock_edge();
      if (busy === 1'b1) n++;
    end
    checks++;
    if (n !== 32) $display("FAIL restart_len: got %0d busy cycles want 32", n);
    else passes++;
    idle();
    re = 2'b11;
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      clock_edge();
      checks++;
      if (dout !== 64'h0) $display("FAIL restart_read addr %0d: got %h want 0", a, dout);
      else passes++;
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = 1'b0;
      re  = 2'($urandom);
      we  = 2'($urandom);
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      din   = {$urandom, $urandom};
      clock_edge();
      checks++;
      if (dout[31:0] !== m_dout[0] || dout[63:32] !== m_dout[1] || busy !== m_clear)
        $display("FAIL random cycle %0d: got dout=%h busy=%b want dout=%h%h busy=%b",
                 c, dout, busy, m_dout[1], m_dout[0], m_clear);
      else passes++;
    end
    idle();
  endtask

`ifdef REGFILE_ZERO_REG_EN
  task automatic test_zero_reg();
    idle();
    we = 2'b11; waddr = {5'd1, 5'd0}; din = {32'h13579BDF, 32'hDEADBEEF};
    re = 2'b11; raddr = {5'd1, 5'd0};
    clock_edge();
    checks++;
    if (dout !== {32'h13579BDF, 32'h0}) $display("FAIL zero_bypass: got %h want 13579bdf00000000", dout);
    else passes++;
    idle();
    re = 2'b11; raddr = {5'd1, 5'd0};
    clock_edge();
    checks++;
    if (dout !== {32'h13579BDF, 32'h0}) $display("FAIL zero_later: got %h want 13579bdf00000000", dout);
    else passes++;
    idle();
  endtask
`endif

  initial begin
    idle();
    raddr = '0;
    waddr = '0;
    din   = '0;
    for (int k = 0; k < 32; k++) m_mem[k] = 'x;
    m_dout[0] = '0;
    m_dout[1] = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_reset_mid_sweep();
    test_random();
`ifdef REGFILE_ZERO_REG_EN
    test_zero_reg();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
